mc_control_fsm: RTL
===================

// Module: mc_control_fsm
// PURPOSE
//  Multi-cycle MIPS control unit: the producer side of the ALU control interface. Decodes opcode/funct
//  and sequences fetch/decode/execute/memory/writeback. Drives the datapath mux selects, the
//  register/memory enables and the 4-bit ALU control code (`ALU_* encodings from macro.vh).
//  Memory accesses use a req/ack handshake, so a slow memory stalls the FSM cleanly.
// PARAMETERS
//  CNT_W    32  width of retired-instruction counter
//  ACK_USE  1   1: wait for mem_ack; 0: treat mem_ack as constant 1 (zero-wait memory)
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  opcode       in   6      IR[31:26], valid from DECODE onward
//  funct        in   6      IR[5:0]
//  zero         in   1      ALU zero flag (combinational from datapath)
//  mem_ack      in   1      memory completes the current read/write this cycle
//  mem_read     out  1      read request (held until ack)
//  mem_write    out  1      write request (held until ack)
//  i_or_d       out  1      0 = address from PC, 1 = address from ALUOut
//  ir_write     out  1      load IR (fetch ack cycle only)
//  pc_en        out  1      PC load = pc_write | (pc_write_cond & zero)
//  pc_source    out  2      00 ALU result, 01 ALUOut, 10 jump target
//  alu_src_a    out  1      0 = PC, 1 = reg A
//  alu_src_b    out  2      00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  alu_control  out  4      `ALU_ADD/SUB/AND/OR/NOR/SLT
//  reg_write    out  1      register file write enable
//  reg_dst      out  1      0 = rt, 1 = rd
//  mem_to_reg   out  1      0 = ALUOut, 1 = MDR
//  illegal      out  1      sticky illegal-instruction flag
//  retired      out  CNT_W  count of completed instructions, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset: async to S_RST; every output 0 (alu_control=`ALU_ADD), retired=0, illegal=0. Reset mid-access
//   drops the request in the same instant. First clock after release: S_RST -> FETCH.
//  State register; outputs decoded from state, with enables gated by mem_ack where noted.
//  FETCH: mem_read=1, i_or_d=0, src_a=0, src_b=01, ADD, pc_source=00; on ack: ir_write=1, pc_en=1 -> DECODE;
//   no ack -> stay, no enables.
//  DECODE: src_a=0, src_b=11, ADD (branch target into ALUOut). Next: lw/sw(100011/101011)->MEM_ADDR;
//   R(000000)->EXEC_R; addi/andi/ori/slti(001000/001100/001101/001010)->EXEC_I; beq(000100)->BRANCH;
//   j(000010)->JUMP; any other opcode, or R-type funct not in {add,sub,and,or,nor,slt} -> ILLEGAL.
//  MEM_ADDR: src_a=1, src_b=10, ADD -> MEM_RD (lw) / MEM_WR (sw).
//  MEM_RD: mem_read=1, i_or_d=1; ack -> MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
//  MEM_WR: mem_write=1, i_or_d=1; ack -> FETCH.
//  EXEC_R: src_a=1, src_b=00, alu_control from funct (100000 ADD,100010 SUB,100100 AND,100101 OR,
//   100111 NOR,101010 SLT) -> R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
//  EXEC_I: src_a=1, src_b=10, op by opcode (ADD/AND/OR/SLT) -> I_WB. I_WB: reg_write=1, reg_dst=0 -> FETCH.
//  BRANCH: src_a=1, src_b=00, SUB, pc_source=01, pc_en=zero -> FETCH.
//  JUMP: pc_source=10, pc_en=1 -> FETCH.
//  ILLEGAL: illegal=1, all enables 0, absorbing until reset.
//  Outputs not listed for a state are 0. mem_read and mem_write are never both 1.
//  mem_ack while no request is outstanding is ignored.
//  retired increments by 1 on every transition into FETCH except S_RST->FETCH; wraps to 0.
//  Latency with zero-wait memory: beq/j 3, R/I-type/sw 4, lw 5 cycles; each ack-less cycle adds 1.
// TESTING
//  add (op 0, funct 100000), ack tied 1 -> states F,D,EX_R,R_WB; alu_control=`ALU_ADD; reg_write/reg_dst=1 in
//   cycle 4; retired 0->1.
//  lw with mem_ack low 3 cycles in MEM_RD -> mem_read/i_or_d held 3 extra cycles, 8 cycles total, mem_to_reg=1 at WB.
//  beq with zero=1 then zero=0 -> pc_en=1, pc_source=01 in cycle 3 first time; pc_en=0 second time.
//  opcode 111111 -> illegal=1 from the cycle after DECODE, all enables 0 for 20 cycles; rst_n low clears it.
//  rst_n asserted mid-MEM_WR -> mem_write drops to 0 asynchronously; after release FETCH with retired=0.
//  retired preloaded via CNT_W=4, 16 j instructions -> wraps to 0; slti -> `ALU_SLT with src_b=10.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback, drives the
// datapath selects, register/memory enables and the ALU control code. Memory accesses use a
// req/ack handshake, so a slow memory simply holds the FSM in the access state.
module mc_control_fsm #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned ACK_USE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_control,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  // ALU control encodings shared with the ALU
  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;
  localparam logic [3:0] AluNor = 4'b0100;
  localparam logic [3:0] AluSlt = 4'b0101;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSlt = 6'b101010;

  typedef enum logic [3:0] {
    StRst, StFetch, StDecode, StMemAddr, StMemRd, StMemWb, StMemWr,
    StExecR, StRWb, StExecI, StIWb, StBranch, StJump, StIllegal
  } state_e;

  state_e     state_q, state_d;
  logic       ack;
  logic       retire;
  logic       r_ok;
  logic [3:0] r_alu;
  logic [3:0] i_alu;

  // Zero-wait builds treat every access as completing immediately
  assign ack = (ACK_USE != 0) ? mem_ack : 1'b1;

  // Ack- and flag-gated enables act in the same cycle, so they stay combinational
  assign ir_write = (state_q == StFetch) && ack;
  assign pc_en    = ir_write || (state_q == StJump) || ((state_q == StBranch) && zero);

  // R-type funct decode; unsupported funct codes are flagged as illegal
  always_comb begin
    r_alu = AluAdd;
    r_ok  = 1'b1;
    case (funct)
      FnAdd:   r_alu = AluAdd;
      FnSub:   r_alu = AluSub;
      FnAnd:   r_alu = AluAnd;
      FnOr:    r_alu = AluOr;
      FnNor:   r_alu = AluNor;
      FnSlt:   r_alu = AluSlt;
      default: r_ok  = 1'b0;
    endcase
  end

  // Immediate-op decode by opcode
  always_comb begin
    i_alu = AluAdd;
    case (opcode)
      OpAndi:  i_alu = AluAnd;
      OpOri:   i_alu = AluOr;
      OpSlti:  i_alu = AluSlt;
      default: i_alu = AluAdd;
    endcase
  end

  // Next-state logic; access states wait on ack, ILLEGAL is absorbing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst:     state_d = StFetch;
      StFetch:   if (ack) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw:                    state_d = StMemAddr;
          OpRtype:                       state_d = r_ok ? StExecR : StIllegal;
          OpAddi, OpAndi, OpOri, OpSlti: state_d = StExecI;
          OpBeq:                         state_d = StBranch;
          OpJ:                           state_d = StJump;
          default:                       state_d = StIllegal;
        endcase
      end
      StMemAddr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:   if (ack) state_d = StMemWb;
      StMemWr:   if (ack) state_d = StFetch;
      StExecR:   state_d = StRWb;
      StExecI:   state_d = StIWb;
      StMemWb, StRWb, StIWb, StBranch, StJump: state_d = StFetch;
      StIllegal: state_d = StIllegal;
      default:   state_d = StRst;
    endcase
  end

  // An instruction retires when control returns to FETCH; the reset entry does not count
  assign retire = (state_d == StFetch) && (state_q != StFetch) && (state_q != StRst);

  // State, counter and registered outputs decoded from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRst;
      retired     <= '0;
      illegal     <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      i_or_d      <= 1'b0;
      pc_source   <= 2'b00;
      alu_src_a   <= 1'b0;
      alu_src_b   <= 2'b00;
      alu_control <= AluAdd;
      reg_write   <= 1'b0;
      reg_dst     <= 1'b0;
      mem_to_reg  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) retired <= retired + CNT_W'(1);
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      i_or_d      <= 1'b0;
      pc_source   <= 2'b00;
      alu_src_a   <= 1'b0;
      alu_src_b   <= 2'b00;
      alu_control <= AluAdd;
      reg_write   <= 1'b0;
      reg_dst     <= 1'b0;
      mem_to_reg  <= 1'b0;
      unique case (state_d)
        StFetch: begin
          mem_read  <= 1'b1;
          alu_src_b <= 2'b01;
        end
        StDecode:  alu_src_b <= 2'b11;
        StMemAddr: begin
          alu_src_a <= 1'b1;
          alu_src_b <= 2'b10;
        end
        StMemRd: begin
          mem_read <= 1'b1;
          i_or_d   <= 1'b1;
        end
        StMemWb: begin
          reg_write  <= 1'b1;
          mem_to_reg <= 1'b1;
        end
        StMemWr: begin
          mem_write <= 1'b1;
          i_or_d    <= 1'b1;
        end
        StExecR: begin
          alu_src_a   <= 1'b1;
          alu_control <= r_alu;
        end
        StRWb: begin
          reg_write <= 1'b1;
          reg_dst   <= 1'b1;
        end
        StExecI: begin
          alu_src_a   <= 1'b1;
          alu_src_b   <= 2'b10;
          alu_control <= i_alu;
        end
        StIWb: reg_write <= 1'b1;
        StBranch: begin
          alu_src_a   <= 1'b1;
          alu_control <= AluSub;
          pc_source   <= 2'b01;
        end
        StJump:    pc_source <= 2'b10;
        StIllegal: illegal   <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
